prog_loader: RTL

- UART-fed program loader that writes bytes into the CPU's 16×8 program memory, driving the memory's write side while the CPU's read side is idle.
- Holds the CPU halted during a load, verifies a checksum, then pulses a CPU restart.
- Sits at top level beside the clock divider and runs on the board clock, not the CPU clock.

---
 rtl/prog_loader_pkg.sv | 26 ++
 rtl/prog_loader_if.sv | 11 +
 rtl/prog_loader_uart_rx.sv | 87 ++++++++
 rtl/prog_loader.sv | 138 +++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the UART program loader.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CSUM,
      ERR
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                  input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Program-memory write port driven by the loader.
interface prog_loader_if #(
   parameter int unsigned ADDR_W = 4
);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (output mem_we, mem_addr, mem_wdata);
   modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, half-bit start check, stop-bit check.
module uart_rx
   import prog_loader_pkg::*;
#(
   parameter int unsigned CYC_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_btn,
   input  logic       rx,
   output logic       byte_valid,
   output logic       frame_err,
   output logic [7:0] data
);
   localparam int unsigned CNT_W = $clog2(CYC_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYC_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYC_PER_BIT - 1);

   logic [1:0]       sync_q;
   logic             rx_prev_q;
   logic             rx_s;
   logic             fall;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_d, ferr_d;

   assign rx_s = sync_q[1];
   assign fall = rx_prev_q & ~rx_s;
   assign data = shift_q;

   always_ff @(posedge clk) begin
      if (!rst_btn) begin
         sync_q     <= 2'b11;
         rx_prev_q  <= 1'b1;
         state_q    <= RX_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], rx};
         rx_prev_q  <= rx_s;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_valid <= valid_d;
         frame_err  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (fall) state_d = RX_START;
         end
         RX_START: if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = RX_STOP;
         end
         RX_STOP: if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            state_d = RX_IDLE;
            valid_d = rx_s;
            ferr_d  = ~rx_s;
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/prog_loader.sv
// UART-fed loader for the CPU program memory: sync, length, data, checksum.
// Optional inter-byte timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50000000,
   parameter int unsigned BAUD        = 9600,
   parameter int unsigned ADDR_W      = 4,
   parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYC = CLK_HZ / 10
) (
   input  logic            clk,
   input  logic            rst_btn,
   input  logic            rx,
   prog_loader_if.master   mem,
   output logic            cpu_hold,
   output logic            cpu_rst,
   output logic            err
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic              byte_valid, frame_err, to_hit;
   logic [7:0]        rx_data;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
   logic [7:0]        sum_q, sum_d, wdata_q, wdata_d;
   logic              we_q, we_d, crst_q, crst_d, err_q, err_d, hold_q, hold_d;

   uart_rx #(.CYC_PER_BIT(cycles_per_bit(CLK_HZ, BAUD))) u_rx (
      .clk        (clk),
      .rst_btn    (rst_btn),
      .rx         (rx),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
      .data       (rx_data)
   );

`ifdef PROG_LOADER_TIMEOUT_EN
   logic [31:0] to_q;
   always_ff @(posedge clk) begin
      if (!rst_btn || byte_valid || frame_err || state_q == IDLE || state_q == ERR)
         to_q <= '0;
      else if (!to_hit)
         to_q <= to_q + 1'b1;
   end
   assign to_hit = (to_q == 32'(TIMEOUT_CYC));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_btn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         sum_q   <= '0;
         we_q    <= 1'b0;
         maddr_q <= '0;
         wdata_q <= '0;
         crst_q  <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         crst_q  <= crst_d;
         err_q   <= err_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      we_d    = 1'b0;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      crst_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE, ERR: if (byte_valid && rx_data == SYNC_BYTE) begin
            state_d = LEN;
            err_d   = 1'b0;
         end
         LEN: if (byte_valid) begin
            if (rx_data == 8'd0 || 32'(rx_data) > DEPTH) begin
               state_d = ERR;
            end else begin
               cnt_d   = CNT_W'(rx_data);
               addr_d  = '0;
               sum_d   = '0;
               state_d = DATA;
            end
         end
         DATA: if (byte_valid) begin
            we_d    = 1'b1;
            maddr_d = addr_q;
            wdata_d = rx_data;
            sum_d   = sum_q + rx_data;
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = CSUM;
         end
         CSUM: if (byte_valid) begin
            if (rx_data == sum_q) begin
               state_d = IDLE;
               crst_d  = 1'b1;
            end else begin
               state_d = ERR;
            end
         end
         default: state_d = IDLE;
      endcase
      // A byte landing on the timeout cycle still counts; the timeout only fires when idle.
      if ((state_q == LEN || state_q == DATA || state_q == CSUM) &&
          (frame_err || (to_hit && !byte_valid)))
         state_d = ERR;
      if (state_d == ERR) err_d = 1'b1;
      hold_d = (state_d != IDLE);
   end

   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = maddr_q;
   assign mem.mem_wdata = wdata_q;
   assign cpu_hold      = hold_q;
   assign cpu_rst       = crst_q;
   assign err           = err_q;

endmodule
